dsd_decimator: RTL and testbench
================================

# dsd_decimator

Receive-side counterpart of the delta-sigma modulator: converts a 1-bit DSD/PDM stream back into 16-bit signed PCM. It uses a 3rd-order CIC (cascaded integrator-comb) decimator with a power-of-two ratio. It sits on loopback or test paths: fed from the modulator output bit `y`, it recovers `pcm` for checking against the synth output or for driving the LED level meter.

## Interface
Parameters:
- `DEC_LOG2`, default 8. log2 of the decimation ratio R; R = 2^DEC_LOG2. Legal range 3..8.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`   in  1  bit-valid strobe; `din` is consumed only in cycles where `en`=1.
- `din`  in  1  DSD bit. 1 maps to +1, 0 maps to -1.
- `pcm`  out 16 signed PCM sample; holds its value between updates.
- `valid` out 1 single-cycle pulse: a new `pcm` value is present this cycle.

## Operation
- Datapath width is W = 3*DEC_LOG2 + 2 (26 bits at default). All integrator and comb arithmetic is two's-complement modulo 2^W. Wrap-around is intentional and must not be saturated.
- Integrators I1..I3 update only when `en`=1:
  - I1 += x
  - I2 += I1_new
  - I3 += I2_new
  - x = ±1, sign-extended to W.
- Decimation counter `cnt` (DEC_LOG2 bits):
  - increments on each `en` cycle and wraps from R-1 to 0;
  - an `en` cycle with `cnt`==R-1 raises the internal `dec` strobe for the next cycle.
- Comb chain runs once per `dec`, each stage with one delay register:
  - C1 = I3 - D1, D1 <= I3
  - C2 = C1 - D2, D2 <= C1
  - C3 = C2 - D3, D3 <= C2
- Output scaling:
  - CIC gain is R^3 = 2^(3*DEC_LOG2), so C3 lies in [-2^(3*DEC_LOG2), +2^(3*DEC_LOG2)].
  - `pcm` = saturate16(C3 >>> (3*DEC_LOG2 - 15)), using an arithmetic (floor) shift.
  - Saturation clamps to [-32768, 32767]; only full-scale positive input actually clips.
- Input history before reset is treated as zero. Outputs 1 and 2 after reset are start-up transients. From output 3 onward, `pcm` is the exact steady-state response.

## Timing
- Let T be the cycle in which the `en` sample with `cnt`==R-1 is accepted. Integrators include that sample at the end of T.
- Pipeline, one stage per cycle:
  - T+1: C1/D1 registered.
  - T+2: C2/D2 registered.
  - T+3: C3/D3 registered.
  - T+4: `pcm` updated and `valid`=1 for that cycle only.
- Latency is fixed at 4 clk regardless of `en` activity during T+1..T+4. Because R ≥ 8 exceeds the pipeline depth, successive decimation events never overlap.
- `valid` period equals R `en` pulses: 256 clk with `en` tied high, 1024 clk with `en` every 4th cycle.
- Reset, at any time including mid-block or mid-pipeline:
  - next cycle: all integrators, delays, combs, `cnt` and pipeline flags are 0; `pcm`=0 and `valid`=0;
  - any in-flight sample is discarded; no `valid` fires from pre-reset data;
  - counting restarts, and the first post-reset `valid` follows the R-th accepted `en` sample by 4 clk.
- `en` and `rst` in the same cycle: reset wins and the sample is dropped.

## Test plan
- Reset, then `din`=1 with `en`=1 every cycle (default R=256):
  - output 1 = 5525, since C(258,3) = 2829056 and 2829056 >>> 9 = 5525;
  - outputs 3 and later = 32767 (saturated);
  - `valid` occurs every 256 clk, 4 clk after each 256th sample.
- Reset, then `din`=0 continuous: output 1 = -5526; outputs 3 and later = -32768; no wrap artefacts over 10 000 outputs.
- `din` pattern 1,0,1,0,… continuous: outputs 3 and later = 0 exactly.
- `din` pattern 1,1,1,0 repeating, `en` every cycle: outputs 3 and later = 16384 exactly (mean 0.5 × 2^24 >>> 9). Loop `dsm` with `pcm`=16384 into this block: steady output within ±64 of 16384.
- `en` asserted every 4th cycle with the pattern 1,1,1,0 on accepted bits: same values as the previous scenario, and `valid` spacing = 1024 clk.
- Pulse `rst` for one cycle at `cnt`=100, and separately at T+2:
  - `pcm`=0 and `valid`=0 on the next cycle;
  - no stale `valid` appears;
  - next `valid` arrives exactly 4 clk after the 256th post-reset `en`;
  - transient values match the first scenario.

Source files
------------

// File: rtl/dsd_decimator.sv
// 3rd-order CIC decimator: 1-bit DSD/PDM stream in, 16-bit signed PCM out.
// Decimation ratio R = 2^DEC_LOG2; integrator/comb arithmetic wraps modulo 2^W by design.
module dsd_decimator #(
    parameter int DEC_LOG2 = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               din,
    output logic signed [15:0] pcm,
    output logic               valid
);

    localparam int W   = 3 * DEC_LOG2 + 2;
    localparam int WE  = W + 16;
    localparam int SH  = 3 * DEC_LOG2 - 15;
    localparam int SHR = (SH > 0) ? SH : 0;
    localparam int SHL = (SH < 0) ? -SH : 0;

    localparam logic [DEC_LOG2-1:0] CNT_LAST = '1;
    localparam logic [DEC_LOG2-1:0] CNT_ONE  = {{(DEC_LOG2-1){1'b0}}, 1'b1};

    // Clamp a sign-extended scaled comb result to the 16-bit PCM range.
    function automatic logic signed [15:0] sat16(input logic signed [WE-1:0] v);
        logic hi_any;
        logic hi_all;
        hi_any = |v[WE-2:15];
        hi_all = &v[WE-2:15];
        if (!v[WE-1] && hi_any) begin
            sat16 = 16'sh7FFF;
        end else if (v[WE-1] && !hi_all) begin
            sat16 = 16'sh8000;
        end else begin
            sat16 = v[15:0];
        end
    endfunction

    logic [W-1:0]        w_x;
    logic [W-1:0]        w_i1_n;
    logic [W-1:0]        w_i2_n;
    logic [W-1:0]        w_i3_n;
    logic                w_last;
    logic signed [WE-1:0] w_c3_ext;
    logic signed [WE-1:0] w_scaled;

    logic [W-1:0]        r_i1;
    logic [W-1:0]        r_i2;
    logic [W-1:0]        r_i3;
    logic [DEC_LOG2-1:0] r_cnt;
    logic [W-1:0]        r_c1;
    logic [W-1:0]        r_c2;
    logic [W-1:0]        r_c3;
    logic [W-1:0]        r_d1;
    logic [W-1:0]        r_d2;
    logic [W-1:0]        r_d3;
    logic                r_p1;
    logic                r_p2;
    logic                r_p3;

    // din=1 -> +1, din=0 -> -1 (all ones), already W bits wide.
    assign w_x      = {{(W-1){~din}}, 1'b1};
    assign w_i1_n   = r_i1 + w_x;
    assign w_i2_n   = r_i2 + w_i1_n;
    assign w_i3_n   = r_i3 + w_i2_n;
    assign w_last   = en && (r_cnt == CNT_LAST);
    assign w_c3_ext = {{16{r_c3[W-1]}}, r_c3};
    // Only one of SHL/SHR is non-zero; small ratios need a left shift to reach 16 bits.
    assign w_scaled = (w_c3_ext <<< SHL) >>> SHR;

    // Integrator chain and decimation counter, advanced only on accepted bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i1  <= '0;
            r_i2  <= '0;
            r_i3  <= '0;
            r_cnt <= '0;
        end else if (en) begin
            r_i1  <= w_i1_n;
            r_i2  <= w_i2_n;
            r_i3  <= w_i3_n;
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Comb pipeline: stage 1 takes the integrator value that includes the R-th bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c1 <= '0;
            r_c2 <= '0;
            r_c3 <= '0;
            r_d1 <= '0;
            r_d2 <= '0;
            r_d3 <= '0;
            r_p1 <= 1'b0;
            r_p2 <= 1'b0;
            r_p3 <= 1'b0;
        end else begin
            r_p1 <= w_last;
            r_p2 <= r_p1;
            r_p3 <= r_p2;
            if (w_last) begin
                r_c1 <= w_i3_n - r_d1;
                r_d1 <= w_i3_n;
            end
            if (r_p1) begin
                r_c2 <= r_c1 - r_d2;
                r_d2 <= r_c1;
            end
            if (r_p2) begin
                r_c3 <= r_c2 - r_d3;
                r_d3 <= r_c2;
            end
        end
    end

    // Output register: pcm holds between updates, valid is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcm   <= 16'sd0;
            valid <= 1'b0;
        end else begin
            valid <= r_p3;
            if (r_p3) begin
                pcm <= sat16(w_scaled);
            end
        end
    end

endmodule

// File: tb/tb_dsd_decimator.sv
// Scoreboard bench for dsd_decimator at R=256: stimulus pushes expected PCM and due cycle,
// a negedge monitor pops and compares whenever valid is seen.
module tb_dsd_decimator;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               din;
    logic signed [15:0] pcm;
    logic               valid;

    always #5 clk = ~clk;

    dsd_decimator #(.DEC_LOG2(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (din),
        .pcm  (pcm),
        .valid(valid)
    );

    typedef struct {
        int    val;
        bit    chk;
        int    due;
        string name;
    } exp_t;

    exp_t  sbq[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    nsamp = 0;
    int    nout = 0;
    int    e1, e2, est;
    bit    ok12;
    bit    push_en = 1'b1;
    string sname = "init";

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expectation in value and cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (valid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got valid=1 at cycle %0d, required no pulse", cyc);
            end else begin
                e = sbq.pop_front();
                check({e.name, " cycle"}, cyc, e.due);
                if (e.chk) check({e.name, " pcm"}, int'(pcm), e.val);
            end
        end
    end

    // One accepted bit after `gap` idle cycles; T is the cycle in which en is high.
    task automatic send(input logic b, input int gap);
        int t;
        exp_t e;
        repeat (gap) begin
            en = 1'b0;
            @(posedge clk); #1;
        end
        en  = 1'b1;
        din = b;
        t   = cyc;
        @(posedge clk); #1;
        en  = 1'b0;
        nsamp++;
        if (push_en && (nsamp % 256 == 0)) begin
            nout++;
            e.val  = (nout == 1) ? e1 : (nout == 2) ? e2 : est;
            e.chk  = (nout > 2) || ok12;
            e.due  = t + 4;
            e.name = $sformatf("%s out%0d", sname, nout);
            sbq.push_back(e);
        end
    endtask

    // Reset pulse with a live sample on en, which must be dropped.
    task automatic do_reset(input string nm);
        rst = 1'b1;
        en  = 1'b1;
        din = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        en    = 1'b0;
        nsamp = 0;
        nout  = 0;
        @(negedge clk);
        check({nm, " pcm"}, int'(pcm), 0);
        check({nm, " valid"}, int'(valid), 0);
    endtask

    // Bit 0 of pat is sent first; pattern repeats every 4 accepted bits.
    task automatic run(input string nm, input logic [3:0] pat, input int gap, input int nouts,
                       input int a1, input int a2, input bit c12, input int st);
        sname = nm;
        e1    = a1;
        e2    = a2;
        ok12  = c12;
        est   = st;
        for (int k = 0; k < nouts * 256; k++) send(pat[k % 4], gap);
        repeat (8) @(posedge clk);
        #1;
        check({nm, " pending_outputs"}, sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        din = 1'b0;
        @(posedge clk); #1;

        do_reset("rst_a");
        run("ones", 4'b1111, 0, 4, 5525, 27370, 1'b1, 32767);

        do_reset("rst_b");
        run("zeros", 4'b0000, 0, 20, -5526, -27371, 1'b1, -32768);

        do_reset("rst_c");
        run("alt10", 4'b0101, 0, 4, 32, 31, 1'b1, 0);

        do_reset("rst_d");
        run("p1110", 4'b0111, 0, 5, 0, 0, 1'b0, 16384);

        do_reset("rst_e");
        run("p1110_en4", 4'b0111, 3, 4, 0, 0, 1'b0, 16384);

        // Reset in the middle of a block (cnt = 100).
        do_reset("rst_f0");
        for (int k = 0; k < 100; k++) send(1'b1, 0);
        do_reset("rst_mid_block");
        run("ones_after_mid", 4'b1111, 0, 3, 5525, 27370, 1'b1, 32767);

        // Reset at T+2 while the first output is still in the comb pipeline.
        do_reset("rst_g0");
        push_en = 1'b0;
        for (int k = 0; k < 256; k++) send(1'b1, 0);
        send(1'b1, 0);
        do_reset("rst_mid_pipe");
        push_en = 1'b1;
        run("ones_after_pipe", 4'b1111, 0, 3, 5525, 27370, 1'b1, 32767);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
